// File: rtl/pcie_txab_commit_pkg.sv
// Shared types and TLP header constants for the TX A/B merge with local write commits.
// The header field offsets are bit positions within the first beat's power-user header.
package pcie_txab_commit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCK_A = 2'd1,
        ST_LOCK_B = 2'd2
    } t_arb_state;

    localparam logic [7:0] FMT_MWR32 = 8'h40;
    localparam logic [7:0] FMT_MWR64 = 8'h60;
    localparam logic [7:0] FMT_CPL   = 8'h0A;

    localparam int FMT_TYPE_LO = 24;
    localparam int TAG_LO      = 40;
    localparam int TAG_M_BIT   = 23;
    localparam int TAG_H_BIT   = 19;
    localparam int REQ_ID_LO   = 48;

    typedef struct packed {
        logic [9:0]  tag;
        logic [15:0] req_id;
    } t_commit_entry;

    function automatic logic is_write(input logic [7:0] fmt_type);
        return (fmt_type == FMT_MWR32) || (fmt_type == FMT_MWR64);
    endfunction

endpackage

// File: rtl/pcie_commit_fifo.sv
// Synchronous FIFO of pending write commits; empty/full come from a registered count,
// so a pushed entry becomes visible on the cycle after the push.
module pcie_commit_fifo
    import pcie_txab_commit_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_push,
    input  t_commit_entry i_data,
    input  logic          i_pop,
    output t_commit_entry o_data,
    output logic          o_full,
    output logic          o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    t_commit_entry r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == CNT_FULL);
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/pcie_txab_commit_arb.sv
// Packet-level round-robin merge of AFU TX A and TX B; every MWr leaving on A
// queues a completion-without-data commit toward RX B carrying the write's tag.
module pcie_txab_commit_arb
    import pcie_txab_commit_pkg::*;
#(
    parameter int TDATA_WIDTH  = 512,
    parameter int TUSER_WIDTH  = 10,
    parameter int COMMIT_DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,

    input  logic                     i_tx_a_tvalid,
    output logic                     o_tx_a_tready,
    input  logic [TDATA_WIDTH-1:0]   i_tx_a_tdata,
    input  logic [TDATA_WIDTH/8-1:0] i_tx_a_tkeep,
    input  logic                     i_tx_a_tlast,
    input  logic [TUSER_WIDTH-1:0]   i_tx_a_tuser,

    input  logic                     i_tx_b_tvalid,
    output logic                     o_tx_b_tready,
    input  logic [TDATA_WIDTH-1:0]   i_tx_b_tdata,
    input  logic [TDATA_WIDTH/8-1:0] i_tx_b_tkeep,
    input  logic                     i_tx_b_tlast,
    input  logic [TUSER_WIDTH-1:0]   i_tx_b_tuser,

    output logic                     o_out_tvalid,
    input  logic                     i_out_tready,
    output logic [TDATA_WIDTH-1:0]   o_out_tdata,
    output logic [TDATA_WIDTH/8-1:0] o_out_tkeep,
    output logic                     o_out_tlast,
    output logic [TUSER_WIDTH-1:0]   o_out_tuser,

    output logic                     o_commit_tvalid,
    input  logic                     i_commit_tready,
    output logic [TDATA_WIDTH-1:0]   o_commit_tdata,
    output logic [TDATA_WIDTH/8-1:0] o_commit_tkeep,
    output logic                     o_commit_tlast,
    output logic [TUSER_WIDTH-1:0]   o_commit_tuser,

    output logic [1:0]               o_state
);

    // Every stream here is AXI-S: a beat moves on a cycle where tvalid && tready are
    // both high at the rising edge; tvalid never waits on tready, payload is held while stalled.

    localparam logic [1:0] S_IDLE   = 2'(ST_IDLE);
    localparam logic [1:0] S_LOCK_A = 2'(ST_LOCK_A);
    localparam logic [1:0] S_LOCK_B = 2'(ST_LOCK_B);

    logic [1:0]    r_state;
    logic          r_last_grant_b;
    logic          r_in_pkt;
    logic          r_is_wr;
    t_commit_entry r_entry;

    logic          w_fifo_full;
    logic          w_fifo_empty;
    t_commit_entry w_fifo_data;
    logic          w_a_elig;
    logic          w_b_elig;
    logic          w_pick_a;
    logic          w_pick_b;
    logic          w_sel_a;
    logic          w_sel_b;
    logic          w_hs;
    logic          w_hs_last;
    logic          w_a_hs;
    logic          w_hdr_wr;
    t_commit_entry w_hdr_entry;
    logic          w_push;
    t_commit_entry w_push_entry;
    logic          w_pop;

    // A full commit FIFO only keeps a new A packet from starting.
    assign w_a_elig = i_tx_a_tvalid && !w_fifo_full;
    assign w_b_elig = i_tx_b_tvalid;
    assign w_pick_a = w_a_elig && (!w_b_elig || r_last_grant_b);
    assign w_pick_b = w_b_elig && !w_pick_a;

    always_comb begin
        w_sel_a = 1'b0;
        w_sel_b = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_sel_a = w_pick_a;
                w_sel_b = w_pick_b;
            end
            S_LOCK_A: w_sel_a = 1'b1;
            S_LOCK_B: w_sel_b = 1'b1;
            default: begin
                w_sel_a = 1'b0;
                w_sel_b = 1'b0;
            end
        endcase
        w_sel_a = w_sel_a && i_rst_n;
        w_sel_b = w_sel_b && i_rst_n;
    end

    assign o_out_tvalid  = (w_sel_a && i_tx_a_tvalid) || (w_sel_b && i_tx_b_tvalid);
    assign o_out_tdata   = w_sel_b ? i_tx_b_tdata : i_tx_a_tdata;
    assign o_out_tkeep   = w_sel_b ? i_tx_b_tkeep : i_tx_a_tkeep;
    assign o_out_tlast   = w_sel_b ? i_tx_b_tlast : i_tx_a_tlast;
    assign o_out_tuser   = w_sel_b ? i_tx_b_tuser : i_tx_a_tuser;
    assign o_tx_a_tready = w_sel_a && i_out_tready;
    assign o_tx_b_tready = w_sel_b && i_out_tready;

    assign w_hs      = o_out_tvalid && i_out_tready;
    assign w_hs_last = w_hs && o_out_tlast;
    assign w_a_hs    = w_hs && w_sel_a;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state        <= S_IDLE;
            r_last_grant_b <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A single-beat packet that completes on its grant cycle leaves us in IDLE.
                    if (w_sel_a) begin
                        r_last_grant_b <= 1'b0;
                        r_state        <= w_hs_last ? S_IDLE : S_LOCK_A;
                    end else if (w_sel_b) begin
                        r_last_grant_b <= 1'b1;
                        r_state        <= w_hs_last ? S_IDLE : S_LOCK_B;
                    end
                end
                S_LOCK_A, S_LOCK_B: begin
                    if (w_hs_last) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_hdr_wr           = is_write(i_tx_a_tdata[FMT_TYPE_LO +: 8]);
    assign w_hdr_entry.tag    = {i_tx_a_tdata[TAG_H_BIT], i_tx_a_tdata[TAG_M_BIT],
                                 i_tx_a_tdata[TAG_LO +: 8]};
    assign w_hdr_entry.req_id = i_tx_a_tdata[REQ_ID_LO +: 16];

    // r_in_pkt distinguishes the header beat; the first beat may land in IDLE or LOCK_A.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_in_pkt <= 1'b0;
            r_is_wr  <= 1'b0;
            r_entry  <= '0;
        end else begin
            if (w_hs) begin
                r_in_pkt <= !o_out_tlast;
            end
            if (w_a_hs && !r_in_pkt) begin
                r_is_wr <= w_hdr_wr;
                r_entry <= w_hdr_entry;
            end
        end
    end

    assign w_push       = w_a_hs && o_out_tlast && (r_in_pkt ? r_is_wr : w_hdr_wr);
    assign w_push_entry = r_in_pkt ? r_entry : w_hdr_entry;
    assign w_pop        = o_commit_tvalid && i_commit_tready;

    pcie_commit_fifo #(
        .DEPTH (COMMIT_DEPTH)
    ) u_commit_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign o_commit_tvalid = !w_fifo_empty && i_rst_n;
    assign o_commit_tlast  = 1'b1;
    assign o_commit_tuser  = '0;

    always_comb begin
        o_commit_tdata = '0;
        o_commit_tdata[FMT_TYPE_LO +: 8] = FMT_CPL;
        o_commit_tdata[TAG_H_BIT]        = w_fifo_data.tag[9];
        o_commit_tdata[TAG_M_BIT]        = w_fifo_data.tag[8];
        o_commit_tdata[TAG_LO +: 8]      = w_fifo_data.tag[7:0];
        o_commit_tdata[REQ_ID_LO +: 16]  = w_fifo_data.req_id;
        o_commit_tkeep         = '0;
        o_commit_tkeep[31:0]   = '1;
    end

    assign o_state = r_state;

endmodule

// File: tb/tb_pcie_txab_commit_arb.sv
// Bench for pcie_txab_commit_arb: queue-driven A/B sources, scoreboard on the merged
// and commit streams, scenario tasks for arbitration, back-pressure and reset.
module tb_pcie_txab_commit_arb;

  localparam int DW = 512;
  localparam int KW = DW / 8;
  localparam int UW = 10;
  localparam logic [KW-1:0] KEEP_LOW = 64'h0000_0000_FFFF_FFFF;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic [UW-1:0] user;
  } beat_t;

  // clock / reset
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          tx_a_tvalid, tx_a_tready, tx_a_tlast;
  logic [DW-1:0] tx_a_tdata;
  logic [KW-1:0] tx_a_tkeep;
  logic [UW-1:0] tx_a_tuser;
  logic          tx_b_tvalid, tx_b_tready, tx_b_tlast;
  logic [DW-1:0] tx_b_tdata;
  logic [KW-1:0] tx_b_tkeep;
  logic [UW-1:0] tx_b_tuser;
  logic          out_tvalid, out_tready, out_tlast;
  logic [DW-1:0] out_tdata;
  logic [KW-1:0] out_tkeep;
  logic [UW-1:0] out_tuser;
  logic          commit_tvalid, commit_tready, commit_tlast;
  logic [DW-1:0] commit_tdata;
  logic [KW-1:0] commit_tkeep;
  logic [UW-1:0] commit_tuser;
  logic [1:0]    state;

  pcie_txab_commit_arb #(
    .TDATA_WIDTH  (DW),
    .TUSER_WIDTH  (UW),
    .COMMIT_DEPTH (8)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_tx_a_tvalid   (tx_a_tvalid),
    .o_tx_a_tready   (tx_a_tready),
    .i_tx_a_tdata    (tx_a_tdata),
    .i_tx_a_tkeep    (tx_a_tkeep),
    .i_tx_a_tlast    (tx_a_tlast),
    .i_tx_a_tuser    (tx_a_tuser),
    .i_tx_b_tvalid   (tx_b_tvalid),
    .o_tx_b_tready   (tx_b_tready),
    .i_tx_b_tdata    (tx_b_tdata),
    .i_tx_b_tkeep    (tx_b_tkeep),
    .i_tx_b_tlast    (tx_b_tlast),
    .i_tx_b_tuser    (tx_b_tuser),
    .o_out_tvalid    (out_tvalid),
    .i_out_tready    (out_tready),
    .o_out_tdata     (out_tdata),
    .o_out_tkeep     (out_tkeep),
    .o_out_tlast     (out_tlast),
    .o_out_tuser     (out_tuser),
    .o_commit_tvalid (commit_tvalid),
    .i_commit_tready (commit_tready),
    .o_commit_tdata  (commit_tdata),
    .o_commit_tkeep  (commit_tkeep),
    .o_commit_tlast  (commit_tlast),
    .o_commit_tuser  (commit_tuser),
    .o_state         (state)
  );

  // scoreboard state
  beat_t       a_q[$];
  beat_t       b_q[$];
  beat_t       exp_a[$];
  beat_t       exp_b[$];
  logic [25:0] exp_c_q[$];
  int          grant_log[$];
  int          cur_lock;
  int          n_vec;
  int          n_err;
  logic        toggle_en;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  function automatic beat_t make_beat(input logic [7:0] fmt, input logic [9:0] tag,
                                      input logic [15:0] rid, input int idx, input int nbeats);
    beat_t b;
    b.data = rand_data();
    if (idx == 0) begin
      b.data[31:24] = fmt;
      b.data[19]    = tag[9];
      b.data[23]    = tag[8];
      b.data[47:40] = tag[7:0];
      b.data[63:48] = rid;
    end
    b.last = (idx == nbeats - 1);
    b.keep = b.last ? KEEP_LOW : '1;
    b.user = UW'($urandom_range(0, 511) * 2);
    return b;
  endfunction

  // driver tasks
  task automatic send_a(input logic [7:0] fmt, input logic [9:0] tag,
                        input logic [15:0] rid, input int nbeats);
    beat_t b;
    for (int i = 0; i < nbeats; i++) begin
      b = make_beat(fmt, tag, rid, i, nbeats);
      a_q.push_back(b);
      exp_a.push_back(b);
    end
    if (fmt == 8'h40 || fmt == 8'h60) exp_c_q.push_back({tag, rid});
  endtask

  task automatic send_b(input int nbeats);
    beat_t b;
    for (int i = 0; i < nbeats; i++) begin
      b = make_beat(8'h20, 10'($urandom_range(0, 1023)), 16'($urandom()), i, nbeats);
      b_q.push_back(b);
      exp_b.push_back(b);
    end
  endtask

  initial begin : drive_a
    logic hs;
    tx_a_tvalid = 1'b0; tx_a_tdata = '0; tx_a_tkeep = '0; tx_a_tlast = 1'b0; tx_a_tuser = '0;
    forever begin
      @(negedge clk);
      hs = tx_a_tvalid && tx_a_tready;
      @(posedge clk);
      if (hs && a_q.size() > 0) void'(a_q.pop_front());
      #1;
      if (a_q.size() > 0) begin
        tx_a_tvalid = 1'b1;
        {tx_a_tdata, tx_a_tkeep, tx_a_tlast, tx_a_tuser} = a_q[0];
      end else begin
        tx_a_tvalid = 1'b0;
      end
    end
  end

  initial begin : drive_b
    logic hs;
    tx_b_tvalid = 1'b0; tx_b_tdata = '0; tx_b_tkeep = '0; tx_b_tlast = 1'b0; tx_b_tuser = '0;
    forever begin
      @(negedge clk);
      hs = tx_b_tvalid && tx_b_tready;
      @(posedge clk);
      if (hs && b_q.size() > 0) void'(b_q.pop_front());
      #1;
      if (b_q.size() > 0) begin
        tx_b_tvalid = 1'b1;
        {tx_b_tdata, tx_b_tkeep, tx_b_tlast, tx_b_tuser} = b_q[0];
      end else begin
        tx_b_tvalid = 1'b0;
      end
    end
  end

  initial begin : toggle_ready
    forever begin
      @(posedge clk);
      #2;
      if (toggle_en) out_tready = ~out_tready;
    end
  end

  // monitor: merged stream and commit stream against expected queues
  always @(negedge clk) begin : monitor
    logic          a_hs, b_hs;
    beat_t         e;
    logic [25:0]   ec;
    logic [DW-1:0] ed;
    if (rst_n && out_tvalid && out_tready) begin
      n_vec++;
      a_hs = tx_a_tvalid && tx_a_tready;
      b_hs = tx_b_tvalid && tx_b_tready;
      if (a_hs == b_hs) begin
        n_err++;
        $display("FAIL out_src: a_hs=%0b b_hs=%0b required exactly one", a_hs, b_hs);
      end else if ((a_hs && exp_a.size() == 0) || (b_hs && exp_b.size() == 0)) begin
        n_err++;
        $display("FAIL out_extra: beat from %s with nothing expected", a_hs ? "A" : "B");
      end else begin
        e = a_hs ? exp_a.pop_front() : exp_b.pop_front();
        if (cur_lock == 0) grant_log.push_back(a_hs ? 0 : 1);
        if ((cur_lock == 1 && b_hs) || (cur_lock == 2 && a_hs)) begin
          n_err++;
          $display("FAIL out_lock: beat from %s while locked to %0d", a_hs ? "A" : "B", cur_lock);
        end else if (out_tdata !== e.data || out_tkeep !== e.keep ||
                     out_tlast !== e.last || out_tuser !== e.user) begin
          n_err++;
          $display("FAIL out_beat: got hdr=%h last=%b user=%h keep=%h required hdr=%h last=%b user=%h keep=%h",
                   out_tdata[63:0], out_tlast, out_tuser, out_tkeep,
                   e.data[63:0], e.last, e.user, e.keep);
        end
        cur_lock = out_tlast ? 0 : (a_hs ? 1 : 2);
      end
    end
    if (rst_n && commit_tvalid && commit_tready) begin
      n_vec++;
      if (exp_c_q.size() == 0) begin
        n_err++;
        $display("FAIL commit_extra: got hdr=%h with none expected", commit_tdata[63:0]);
      end else begin
        ec = exp_c_q.pop_front();
        ed = '0;
        ed[31:24] = 8'h0A;
        ed[19]    = ec[25];
        ed[23]    = ec[24];
        ed[47:40] = ec[23:16];
        ed[63:48] = ec[15:0];
        if (commit_tdata !== ed || commit_tkeep !== KEEP_LOW ||
            commit_tlast !== 1'b1 || commit_tuser !== '0) begin
          n_err++;
          $display("FAIL commit: got hdr=%h keep=%h last=%b user=%h required hdr=%h keep=%h last=1 user=0",
                   commit_tdata[63:0], commit_tkeep, commit_tlast, commit_tuser, ed[63:0], KEEP_LOW);
        end
      end
    end
  end

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((a_q.size() + b_q.size() + exp_a.size() + exp_b.size() + exp_c_q.size()) > 0
           && n < budget) begin
      tick();
      n++;
    end
    n_vec++;
    if ((a_q.size() + b_q.size() + exp_a.size() + exp_b.size() + exp_c_q.size()) > 0) begin
      n_err++;
      $display("FAIL %s_drain: left a=%0d b=%0d ea=%0d eb=%0d ec=%0d required all 0",
               name, a_q.size(), b_q.size(), exp_a.size(), exp_b.size(), exp_c_q.size());
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    cur_lock = 0;
    tick();
  endtask

  // scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    n_vec++;
    if (out_tvalid !== 1'b0 || commit_tvalid !== 1'b0 || tx_a_tready !== 1'b0 ||
        tx_b_tready !== 1'b0 || state !== 2'd0) begin
      n_err++;
      $display("FAIL reset_outputs: ov=%b cv=%b ar=%b br=%b st=%0d required all 0",
               out_tvalid, commit_tvalid, tx_a_tready, tx_b_tready, state);
    end
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    n_vec++;
    if (out_tvalid !== 1'b0 || tx_a_tready !== 1'b0 || tx_b_tready !== 1'b0 || state !== 2'd0) begin
      n_err++;
      $display("FAIL idle_outputs: ov=%b ar=%b br=%b st=%0d required all 0",
               out_tvalid, tx_a_tready, tx_b_tready, state);
    end
    tick();
  endtask

  task automatic test_alternate();
    do_reset();
    grant_log.delete();
    for (int i = 0; i < 4; i++) begin
      send_a(8'h40, 10'(i * 37 + 5), 16'(16'h1000 + i), 1);
      send_b(1);
    end
    wait_drain("alternate", 60);
    n_vec++;
    if (grant_log.size() != 8) begin
      n_err++;
      $display("FAIL alt_count: got %0d grants required 8", grant_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_vec++;
        if (grant_log[i] != (i % 2)) begin
          n_err++;
          $display("FAIL alt_order[%0d]: got %s required %s", i,
                   grant_log[i] == 0 ? "A" : "B", (i % 2) == 0 ? "A" : "B");
        end
      end
    end
  endtask

  task automatic test_single_write();
    logic seen;
    seen = 1'b0;
    send_a(8'h60, 10'h155, 16'h0100, 2);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (out_tvalid && out_tready && out_tlast) begin
        seen = 1'b1;
        n_vec++;
        if (commit_tvalid !== 1'b0) begin
          n_err++;
          $display("FAIL commit_early: commit_tvalid=%b at tlast required 0", commit_tvalid);
        end
        @(negedge clk);
        n_vec++;
        if (commit_tvalid !== 1'b1 || commit_tdata[31:24] !== 8'h0A ||
            {commit_tdata[19], commit_tdata[23], commit_tdata[47:40]} !== 10'h155 ||
            commit_tdata[63:48] !== 16'h0100) begin
          n_err++;
          $display("FAIL commit_latency: v=%b hdr=%h required v=1 fmt=0a tag=155 rid=0100",
                   commit_tvalid, commit_tdata[63:0]);
        end
      end
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL single_tlast: no tlast within 20 cycles required one");
    end
    tick();
    wait_drain("single", 20);
  endtask

  task automatic test_mrd();
    send_a(8'h20, 10'h0F0, 16'h0200, 2);
    wait_drain("mrd", 20);
    repeat (3) begin
      @(negedge clk);
      n_vec++;
      if (commit_tvalid !== 1'b0) begin
        n_err++;
        $display("FAIL mrd_commit: commit_tvalid=%b required 0", commit_tvalid);
      end
    end
    tick();
  endtask

  task automatic test_fifo_full();
    commit_tready = 1'b0;
    for (int i = 0; i < 9; i++) send_a((i % 2) ? 8'h40 : 8'h60, 10'(10'h300 + i * 11), 16'(16'hA000 + i), 1);
    for (int i = 0; i < 4; i++) send_b(2);
    repeat (40) tick();
    n_vec++;
    if (a_q.size() != 1 || b_q.size() != 0) begin
      n_err++;
      $display("FAIL full_stall: a_left=%0d b_left=%0d required 1 and 0", a_q.size(), b_q.size());
    end
    @(negedge clk);
    n_vec++;
    if (tx_a_tvalid !== 1'b1 || tx_a_tready !== 1'b0) begin
      n_err++;
      $display("FAIL full_ready: a_valid=%b a_ready=%b required 1 and 0", tx_a_tvalid, tx_a_tready);
    end
    tick();
    commit_tready = 1'b1;
    tick();
    commit_tready = 1'b0;
    repeat (5) tick();
    n_vec++;
    if (a_q.size() != 0 || exp_c_q.size() != 8) begin
      n_err++;
      $display("FAIL full_admit: a_left=%0d commits_pending=%0d required 0 and 8",
               a_q.size(), exp_c_q.size());
    end
    commit_tready = 1'b1;
    wait_drain("full", 40);
  endtask

  task automatic test_b_toggle();
    int locked;
    locked = 0;
    send_b(4);
    tick();
    toggle_en = 1'b1;
    send_a(8'h40, 10'h2C3, 16'h0333, 3);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      #1;
      if (cur_lock == 2) begin
        locked++;
        n_vec++;
        if (tx_a_tready !== 1'b0) begin
          n_err++;
          $display("FAIL toggle_block: a_ready=%b during B packet required 0", tx_a_tready);
        end
      end
    end
    n_vec++;
    if (locked == 0) begin
      n_err++;
      $display("FAIL toggle_lock: locked cycles=%0d required >0", locked);
    end
    tick();
    toggle_en = 1'b0;
    out_tready = 1'b1;
    wait_drain("toggle", 40);
  endtask

  task automatic test_reset_mid();
    int n;
    commit_tready = 1'b0;
    for (int i = 0; i < 3; i++) send_a(8'h40, 10'(10'h100 + i), 16'(16'h0C00 + i), 1);
    n = 0;
    while (a_q.size() > 0 && n < 30) begin tick(); n++; end
    send_a(8'h60, 10'h3FF, 16'h7777, 4);
    n = 0;
    while (!(a_q.size() > 0 && a_q.size() < 4) && n < 30) begin tick(); n++; end
    n_vec++;
    if (!(a_q.size() > 0 && a_q.size() < 4) || exp_c_q.size() != 4) begin
      n_err++;
      $display("FAIL mid_setup: a_left=%0d commits_exp=%0d required 1..3 and 4",
               a_q.size(), exp_c_q.size());
    end
    rst_n = 1'b0;
    a_q.delete();
    exp_a.delete();
    exp_c_q.delete();
    tx_a_tvalid = 1'b0;
    cur_lock = 0;
    @(negedge clk);
    n_vec++;
    if (out_tvalid !== 1'b0 || commit_tvalid !== 1'b0 || tx_a_tready !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_out: ov=%b cv=%b ar=%b required 0", out_tvalid, commit_tvalid, tx_a_tready);
    end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (state !== 2'd0 || commit_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset_state: st=%0d cv=%b required 0 and 0", state, commit_tvalid);
    end
    tick();
    commit_tready = 1'b1;
    send_a(8'h40, 10'h2AA, 16'hBEEF, 1);
    wait_drain("post_reset", 20);
    repeat (5) tick();
    n_vec++;
    if (commit_tvalid !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_extra: commit_tvalid=%b required 0", commit_tvalid);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    cur_lock = 0;
    toggle_en = 1'b0;
    rst_n = 1'b0;
    out_tready = 1'b1;
    commit_tready = 1'b1;
    test_reset();
    test_alternate();
    test_single_write();
    test_mrd();
    test_fifo_full();
    test_b_toggle();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
